// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left and parallel load, plus an
// autonomous burst engine that shifts a latched count of positions with busy/done.
module univ_shift_reg #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          CNT_W     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             dir_l;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shl;

  assign shr     = {ser_in_l, q[WIDTH-1:1]};
  assign shl     = {q[WIDTH-2:0], ser_in_r};
  assign msb_out = q[WIDTH-1];
  assign lsb_out = q[0];

  // Direct-mode datapath in IDLE; the burst engine owns q while in SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET_VAL;
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      dir_l     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              remaining <= count;
              dir_l     <= dir;
              state     <= SHIFT;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            case (mode)
              MODE_HOLD:  q <= q;
              MODE_RIGHT: q <= shr;
              MODE_LEFT:  q <= shl;
              MODE_LOAD:  q <= par_in;
              default:    q <= q;
            endcase
          end
        end
        SHIFT: begin
          q         <= dir_l ? shl : shr;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: direct modes, bursts, zero-count, back-to-back
// and mid-burst reset, with hand-computed expected values.
module tb_univ_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic             msb_out;
  logic             lsb_out;
  logic             busy;
  logic             done;

  int tests  = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .par_in   (par_in),
    .start    (start),
    .dir      (dir),
    .count    (count),
    .q        (q),
    .msb_out  (msb_out),
    .lsb_out  (lsb_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stat(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    rst = 1'b0; mode = 2'b00; ser_in_l = 1'b0; ser_in_r = 1'b0;
    par_in = '0; start = 1'b0; dir = 1'b0; count = '0;

    // Reset from a non-zero register
    mode = 2'b11; par_in = 8'hFF; step();
    check("preload", 32'(q), 32'hFF);
    rst = 1'b1; step();
    check_stat("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Parallel load then shift right
    mode = 2'b11; par_in = 8'hA5; step();
    check("load_a5", 32'(q), 32'hA5);
    mode = 2'b01; ser_in_l = 1'b1; step();
    check("shr", 32'(q), 32'hD2);
    check("shr.msb", 32'(msb_out), 32'h1);
    check("shr.lsb", 32'(lsb_out), 32'h0);

    // Shift left then hold
    mode = 2'b11; par_in = 8'hA5; step();
    mode = 2'b10; ser_in_r = 1'b0; step();
    check("shl", 32'(q), 32'h4A);
    check("shl.msb", 32'(msb_out), 32'h0);
    check("shl.lsb", 32'(lsb_out), 32'h0);
    mode = 2'b00; step();
    check("hold", 32'(q), 32'h4A);

    // Left burst of 3 with start held high (no retrigger) and mode ignored
    mode = 2'b11; par_in = 8'h81; step();
    par_in = 8'h00; start = 1'b1; dir = 1'b1; count = 4'd3; ser_in_r = 1'b1; step();
    check_stat("b3.accept", 8'h81, 1'b1, 1'b0);
    step();
    check_stat("b3.s1", 8'h03, 1'b1, 1'b0);
    step();
    check_stat("b3.s2", 8'h07, 1'b1, 1'b0);
    start = 1'b0; step();
    check_stat("b3.s3", 8'h0F, 1'b0, 1'b1);
    mode = 2'b00; step();
    check_stat("b3.after", 8'h0F, 1'b0, 1'b0);

    // Zero-count burst
    mode = 2'b11; par_in = 8'h3C; step();
    start = 1'b1; count = 4'd0; step();
    check_stat("b0", 8'h3C, 1'b0, 1'b1);
    start = 1'b0; mode = 2'b00; step();
    check_stat("b0.after", 8'h3C, 1'b0, 1'b0);

    // Right burst longer than WIDTH fills with serial input
    mode = 2'b11; par_in = 8'h00; step();
    start = 1'b1; dir = 1'b0; count = 4'd10; ser_in_l = 1'b1; step();
    start = 1'b0;
    check_stat("b10.accept", 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step();
    check_stat("b10.s9", 8'hFF, 1'b1, 1'b0);
    step();
    check_stat("b10.s10", 8'hFF, 1'b0, 1'b1);

    // Back-to-back: start in the done cycle is accepted
    start = 1'b1; count = 4'd1; dir = 1'b0; ser_in_l = 1'b0; step();
    check_stat("b2b.accept", 8'hFF, 1'b1, 1'b0);
    start = 1'b0; step();
    check_stat("b2b.s1", 8'h7F, 1'b0, 1'b1);

    // Mid-burst reset aborts without done; start during burst ignored
    mode = 2'b00; start = 1'b1; count = 4'd5; dir = 1'b1; ser_in_r = 1'b0; step();
    check_stat("rb.accept", 8'h7F, 1'b1, 1'b0);
    count = 4'd0; step();
    check_stat("rb.s1", 8'hFE, 1'b1, 1'b0);
    rst = 1'b1; step();
    check_stat("rb.rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0; step();
    check_stat("rb.after", 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
